// File: rtl/collection_pkg.sv
// Shared constants for the data-collection BRAM read path: arbiter FSM encoding,
// default widths and the BRAM word indices of the tracking-solution fields.
package collection_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  // Tracking-solution words in the collection BRAM
  localparam int AZ_WORD    = 4;
  localparam int EL_WORD    = 5;
  localparam int RANGE_WORD = 6;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

endpackage

// File: rtl/collection_read_arbiter_rr_pick.sv
// Combinational round-robin pick: first pending requester at or above ptr,
// wrapping to the lowest pending requester below ptr.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Upper segment [ptr..NUM_REQ-1] has priority over the wrapped segment
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (IW'(i) >= ptr)) begin
        any      = 1'b1;
        idx      = IW'(i);
        grant[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (IW'(i) < ptr)) begin
        any      = 1'b1;
        idx      = IW'(i);
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collection_read_arbiter.sv
// Round-robin owner of the collection BRAM read port: one o_run per accepted
// request, response on the next rising read-valid edge or an error on timeout.
module collection_read_arbiter
  import collection_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 63
) (
  input  logic                      system_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_mode,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_error,
  output logic [ADDR_W-1:0]         o_bram_addr,
  output logic                      o_mode,
  output logic                      o_run,
  input  logic [DATA_W-1:0]         i_read_data,
  input  logic                      i_read_valid
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic [7:0]         cnt;
  logic               vld_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_mode;
  logic               vld_rise;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_mode = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_mode = req_mode[i];
      end
    end
  end

  // A valid left high by the previous read must not complete the current one
  assign vld_rise = i_read_valid && !vld_q;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      win_idx     <= '0;
      win_grant   <= '0;
      cnt         <= '0;
      vld_q       <= 1'b0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
      o_bram_addr <= '0;
      o_mode      <= 1'b0;
      o_run       <= 1'b0;
    end else begin
      vld_q     <= i_read_valid;
      o_run     <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            win_idx     <= pick_idx;
            win_grant   <= pick_grant;
            o_bram_addr <= sel_addr;
            o_mode      <= sel_mode;
            o_run       <= 1'b1;
            req_ready   <= pick_grant;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rr_ptr <= (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
          cnt    <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (vld_rise) begin
            rsp_data  <= i_read_data;
            rsp_error <= 1'b0;
            rsp_valid <= win_grant;
            state     <= S_RESP;
          end else if (cnt == 8'(TIMEOUT)) begin
            rsp_data  <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= win_grant;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collection_read_arbiter.sv
// Directed bench for collection_read_arbiter: inputs change 1ns after posedge,
// outputs are sampled on the negedge of the same cycle.
module tb_collection_read_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 63;

  logic                      system_clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_mode;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_error;
  logic [ADDR_W-1:0]         o_bram_addr;
  logic                      o_mode;
  logic                      o_run;
  logic [DATA_W-1:0]         i_read_data;
  logic                      i_read_valid;

  int checks;
  int failures;

  collection_read_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .system_clk   (system_clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_mode     (req_mode),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_error    (rsp_error),
    .o_bram_addr  (o_bram_addr),
    .o_mode       (o_mode),
    .o_run        (o_run),
    .i_read_data  (i_read_data),
    .i_read_valid (i_read_valid)
  );

  initial system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  task automatic step();
    @(posedge system_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0; req_addr = '0; req_mode = '0;
    i_read_data = '0; i_read_valid = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge system_clk);
    #1;
    checks++;
    if ({o_run, req_ready, rsp_valid, rsp_error, o_mode, o_bram_addr, rsp_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: run=%b ready=%b rsp=%b err=%b addr=%0d data=%h, want all 0",
               o_run, req_ready, rsp_valid, rsp_error, o_bram_addr, rsp_data);
    end
    reset = 1'b1;
    step();
    step();
    @(negedge system_clk);
    checks++;
    if ({o_run, req_ready, rsp_valid} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: run=%b ready=%b rsp=%b, want 0", o_run, req_ready, rsp_valid);
    end
  endtask

  task automatic test_single();
    step();
    req_valid = 2'b01; req_addr = {10'd0, 10'd4}; req_mode = 2'b00;
    step();
    @(negedge system_clk);
    checks++;
    if ({o_run, req_ready, o_bram_addr, o_mode} !== {1'b1, 2'b01, 10'd4, 1'b0}) begin
      failures++;
      $display("FAIL single_issue: run=%b ready=%b addr=%0d mode=%b, want 1 01 4 0",
               o_run, req_ready, o_bram_addr, o_mode);
    end
    step();
    req_valid = 2'b00;
    @(negedge system_clk);
    checks++;
    if ({o_run, req_ready, o_bram_addr} !== {1'b0, 2'b00, 10'd4}) begin
      failures++;
      $display("FAIL single_wait: run=%b ready=%b addr=%0d, want 0 00 4", o_run, req_ready, o_bram_addr);
    end
    step();
    step();
    i_read_valid = 1'b1; i_read_data = 32'h0000_3ACA;
    @(negedge system_clk);
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_early_rsp: rsp=%b, want 00", rsp_valid);
    end
    step();
    @(negedge system_clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_error} !== {2'b01, 32'h0000_3ACA, 1'b0}) begin
      failures++;
      $display("FAIL single_rsp: rsp=%b data=%h err=%b, want 01 00003aca 0", rsp_valid, rsp_data, rsp_error);
    end
    step();
    i_read_valid = 1'b0;
    @(negedge system_clk);
    checks++;
    if ({rsp_valid, rsp_data} !== {2'b00, 32'h0000_3ACA}) begin
      failures++;
      $display("FAIL single_hold: rsp=%b data=%h, want 00 00003aca", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_reset_mid_wait();
    // Requester 0 granted leaves rr pointer at 1; reset must bring it back to 0
    step();
    req_valid = 2'b01; req_addr = {10'd0, 10'd5};
    step();
    step();
    req_valid = 2'b00;
    step();
    reset = 1'b0;
    i_read_valid = 1'b1; i_read_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({o_run, req_ready, rsp_valid, rsp_error, o_mode, o_bram_addr, rsp_data} !== '0) begin
      failures++;
      $display("FAIL reset_mid_wait: run=%b rsp=%b addr=%0d data=%h, want all 0",
               o_run, rsp_valid, o_bram_addr, rsp_data);
    end
    step();
    step();
    reset = 1'b1;
    step();
    step();
    @(negedge system_clk);
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL aborted_rsp_discarded: rsp=%b, want 00", rsp_valid);
    end
    step();
    i_read_valid = 1'b0;
  endtask

  task automatic test_contention();
    logic [NUM_REQ-1:0] exp_g [3];
    logic [ADDR_W-1:0]  exp_a [3];
    logic [DATA_W-1:0]  dat   [3];
    logic               seen;
    exp_g = '{2'b01, 2'b10, 2'b01};
    exp_a = '{10'd5, 10'd6, 10'd5};
    dat   = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
    req_valid = 2'b11; req_addr = {10'd6, 10'd5}; req_mode = 2'b10;
    for (int g = 0; g < 3; g++) begin
      seen = 1'b0;
      for (int t = 0; t < 8 && !seen; t++) begin
        @(negedge system_clk);
        if (req_ready !== 2'b00) seen = 1'b1;
        else step();
      end
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL contention_grant_timeout: grant %0d never arrived", g);
      end else if ({req_ready, o_bram_addr, o_mode} !== {exp_g[g], exp_a[g], exp_g[g][1]}) begin
        failures++;
        $display("FAIL contention_grant%0d: ready=%b addr=%0d mode=%b, want %b %0d %b",
                 g, req_ready, o_bram_addr, o_mode, exp_g[g], exp_a[g], exp_g[g][1]);
      end
      step();
      i_read_valid = 1'b1; i_read_data = dat[g];
      step();
      @(negedge system_clk);
      checks++;
      if ({rsp_valid, rsp_data, rsp_error} !== {exp_g[g], dat[g], 1'b0}) begin
        failures++;
        $display("FAIL contention_rsp%0d: rsp=%b data=%h err=%b, want %b %h 0",
                 g, rsp_valid, rsp_data, rsp_error, exp_g[g], dat[g]);
      end
      step();
      i_read_valid = 1'b0;
      if (g == 2) req_valid = 2'b00;
    end
  endtask

  task automatic test_level_valid();
    logic early;
    // rr pointer is 1 here, so requester 1 goes first
    req_valid = 2'b10; req_addr = {10'd5, 10'd0}; req_mode = 2'b00;
    step();
    @(negedge system_clk);
    checks++;
    if ({req_ready, o_bram_addr} !== {2'b10, 10'd5}) begin
      failures++;
      $display("FAIL level_first_issue: ready=%b addr=%0d, want 10 5", req_ready, o_bram_addr);
    end
    step();
    req_valid = 2'b00;
    i_read_valid = 1'b1; i_read_data = 32'h1111_2222;
    step();
    @(negedge system_clk);
    checks++;
    if ({rsp_valid, rsp_data} !== {2'b10, 32'h1111_2222}) begin
      failures++;
      $display("FAIL level_first_rsp: rsp=%b data=%h, want 10 11112222", rsp_valid, rsp_data);
    end
    step();
    i_read_data = 32'h3333_4444;
    req_valid = 2'b01; req_addr = {10'd0, 10'd6};
    step();
    @(negedge system_clk);
    checks++;
    if ({req_ready, o_bram_addr, o_run} !== {2'b01, 10'd6, 1'b1}) begin
      failures++;
      $display("FAIL level_second_issue: ready=%b addr=%0d run=%b, want 01 6 1", req_ready, o_bram_addr, o_run);
    end
    step();
    req_valid = 2'b00;
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge system_clk);
      if (rsp_valid !== 2'b00) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL level_stale_valid: response on held-high valid, want none");
    end
    step();
    i_read_valid = 1'b0;
    step();
    i_read_valid = 1'b1;
    step();
    @(negedge system_clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_error} !== {2'b01, 32'h3333_4444, 1'b0}) begin
      failures++;
      $display("FAIL level_second_rsp: rsp=%b data=%h err=%b, want 01 33334444 0", rsp_valid, rsp_data, rsp_error);
    end
    step();
    i_read_valid = 1'b0;
  endtask

  task automatic test_timeout();
    logic early;
    req_valid = 2'b01; req_addr = {10'd0, 10'd4};
    step();
    @(negedge system_clk);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL timeout_issue: ready=%b, want 01", req_ready);
    end
    early = 1'b0;
    // 64 WAIT cycles (counter 0..63) without a response
    for (int i = 0; i < 64; i++) begin
      step();
      if (i == 0) req_valid = 2'b00;
      @(negedge system_clk);
      if (rsp_valid !== 2'b00) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: response before 64 WAIT cycles");
    end
    step();
    @(negedge system_clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_error} !== {2'b01, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL timeout_rsp: rsp=%b data=%h err=%b, want 01 00000000 1", rsp_valid, rsp_data, rsp_error);
    end
    step();
    @(negedge system_clk);
    checks++;
    if ({rsp_valid, rsp_error} !== {2'b00, 1'b1}) begin
      failures++;
      $display("FAIL timeout_after: rsp=%b err=%b, want 00 1", rsp_valid, rsp_error);
    end
  endtask

  task automatic test_withdrawn();
    logic stray;
    // Arbiter back in IDLE after the timeout; rr pointer is 1
    req_valid = 2'b01; req_addr = {10'd6, 10'd5};
    step();
    @(negedge system_clk);
    checks++;
    if ({req_ready, o_bram_addr} !== {2'b01, 10'd5}) begin
      failures++;
      $display("FAIL withdrawn_issue: ready=%b addr=%0d, want 01 5", req_ready, o_bram_addr);
    end
    step();
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    i_read_valid = 1'b1; i_read_data = 32'h5555_AAAA;
    step();
    @(negedge system_clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_error} !== {2'b01, 32'h5555_AAAA, 1'b0}) begin
      failures++;
      $display("FAIL withdrawn_rsp0: rsp=%b data=%h err=%b, want 01 5555aaaa 0", rsp_valid, rsp_data, rsp_error);
    end
    step();
    i_read_valid = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge system_clk);
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || o_run !== 1'b0) stray = 1'b1;
      step();
    end
    checks++;
    if (stray !== 1'b0) begin
      failures++;
      $display("FAIL withdrawn_stray: grant or response for withdrawn requester");
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_reset_mid_wait();
    test_contention();
    test_level_valid();
    test_timeout();
    test_withdrawn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
